// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: tick and button inputs, display and status outputs.
// master = board/test side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start_stop_n;
    logic       lap_clr_n;
    logic [3:0] disp_ones;
    logic [3:0] disp_tens;
    logic       running;
    logic       lap_active;
    logic       overflow;

    modport master (
        output tick, start_stop_n, lap_clr_n,
        input  disp_ones, disp_tens, running, lap_active, overflow
    );

    modport slave (
        input  tick, start_stop_n, lap_clr_n,
        output disp_ones, disp_tens, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, start/stop/lap/clear FSM,
// 00-99 BCD seconds count and display mux.
// Optional macro STOPWATCH_OVERFLOW_STOP_EN: stop at 99 with a sticky overflow
// flag instead of wrapping to 00.
//
// state | meaning
// IDLE  | stopped, count cleared
// RUN   | counting, live display
// LAP   | counting, display frozen on lap registers
// PAUSE | stopped, count held
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DEBOUNCE_W      = 17
) (
    input  logic             clock,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    // index 0 = start_stop, index 1 = lap_clr
    logic [1:0]            raw;
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            db;
    logic [1:0]            press;
    logic [DEBOUNCE_W-1:0] db_cnt [2];

    state_t     state;
    logic [3:0] ones, tens;
    logic [3:0] lap_ones, lap_tens;
    logic [3:0] disp_ones, disp_tens;
    logic       ovf;
    logic       start_eff, lap_eff, counting, clear;

    assign raw = {bus.lap_clr_n, bus.start_stop_n};

    // Synchronize, debounce and edge-detect both buttons.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            db     <= 2'b11;
            press  <= 2'b00;
            db_cnt <= '{default: '0};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                        press[i]  <= ~sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Start beats lap in the same cycle; start is locked out while overflowed.
    assign start_eff = press[0] & ~ovf;
    assign lap_eff   = press[1] & ~press[0];
    assign counting  = (state == RUN) || (state == LAP);
    assign clear     = (state == PAUSE) && lap_eff;

`ifdef STOPWATCH_OVERFLOW_STOP_EN
    logic at_max;
    assign at_max = (ones == 4'd9) && (tens == 4'd9);
`else
    assign ovf = 1'b0;
`endif

    // State transitions, lap capture and BCD count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ones     <= '0;
            tens     <= '0;
            lap_ones <= '0;
            lap_tens <= '0;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:  if (start_eff) state <= RUN;
                RUN: begin
                    if (start_eff) begin
                        state <= PAUSE;
                    end else if (lap_eff) begin
                        state    <= LAP;
                        lap_ones <= ones;
                        lap_tens <= tens;
                    end
                end
                LAP: begin
                    if (start_eff)    state <= PAUSE;
                    else if (lap_eff) state <= RUN;
                end
                PAUSE: begin
                    if (start_eff)    state <= RUN;
                    else if (lap_eff) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (clear) begin
                ones <= '0;
                tens <= '0;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
                ovf  <= 1'b0;
`endif
            end else if (bus.tick && counting) begin
`ifdef STOPWATCH_OVERFLOW_STOP_EN
                if (at_max) begin
                    state <= PAUSE;
                    ovf   <= 1'b1;
                end else
`endif
                if (ones == 4'd9) begin
                    ones <= '0;
                    tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

    // Display register: lap value in LAP, otherwise the live count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_ones <= '0;
            disp_tens <= '0;
        end else if (state == LAP) begin
            disp_ones <= lap_ones;
            disp_tens <= lap_tens;
        end else begin
            disp_ones <= ones;
            disp_tens <= tens;
        end
    end

    assign bus.disp_ones  = disp_ones;
    assign bus.disp_tens  = disp_tens;
    assign bus.running    = counting;
    assign bus.lap_active = (state == LAP);
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (DEBOUNCE_CYCLES=4): directed scenarios plus
// random button/tick sequences against an event-level stopwatch model.
module tb_stopwatch_ctrl;
    localparam int DB_CYC = 4;
    // button drive -> press pulse visible: 2 sync flops + DB_CYC stable samples
    localparam int PRESS_LAT = 2 + DB_CYC;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB_CYC), .DEBOUNCE_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sw_if.slave)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    int m_state, m_count, m_lap;
    bit m_ovf;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_count = 0; m_lap = 0; m_ovf = 0;
    endtask

    // One button/tick event applied to the stopwatch rules.
    task automatic model_step(input bit s, input bit l, input bit t);
        int pre;
        int c;
        bit se, le;
        pre = m_state;
        c   = m_count;
        se  = s && !m_ovf;
        le  = l && !s;
        case (pre)
            M_IDLE:  if (se) m_state = M_RUN;
            M_RUN:   if (se) m_state = M_PAUSE;
                     else if (le) begin m_state = M_LAP; m_lap = c; end
            M_LAP:   if (se) m_state = M_PAUSE; else if (le) m_state = M_RUN;
            default: if (se) m_state = M_RUN;   else if (le) m_state = M_IDLE;
        endcase
        if (pre == M_PAUSE && le) begin
            m_count = 0;
            m_ovf   = 0;
        end else if (t && (pre == M_RUN || pre == M_LAP)) begin
            if (OVF_EN && c == 99) begin
                m_state = M_PAUSE;
                m_ovf   = 1;
            end else begin
                m_count = (c + 1) % 100;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int shown;
        shown = (m_state == M_LAP) ? m_lap : m_count;
        check({tag, ".ones"},    int'(sw_if.disp_ones), shown % 10);
        check({tag, ".tens"},    int'(sw_if.disp_tens), shown / 10);
        check({tag, ".running"}, int'(sw_if.running),
              (m_state == M_RUN || m_state == M_LAP) ? 1 : 0);
        check({tag, ".lap"},     int'(sw_if.lap_active), (m_state == M_LAP) ? 1 : 0);
        check({tag, ".ovf"},     int'(sw_if.overflow), int'(m_ovf));
    endtask

    // Clean press of one or both buttons, optionally with a tick coincident
    // with the press pulse.
    task automatic press(input bit s, input bit l, input bit t);
        @(posedge clock); #1;
        if (s) sw_if.start_stop_n = 1'b0;
        if (l) sw_if.lap_clr_n    = 1'b0;
        repeat (PRESS_LAT) @(posedge clock);
        #1;
        if (t) sw_if.tick = 1'b1;
        @(posedge clock); #1;
        sw_if.tick = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        sw_if.start_stop_n = 1'b1;
        sw_if.lap_clr_n    = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        model_step(s, l, t);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1; sw_if.tick = 1'b1;
            @(posedge clock); #1; sw_if.tick = 1'b0;
            model_step(1'b0, 1'b0, 1'b1);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        sw_if.tick = 1'b0;
        sw_if.start_stop_n = 1'b1;
        sw_if.lap_clr_n = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // start, 12 ticks, stop, display holds
        press(1, 0, 0);
        do_ticks(12);
        check_all("run12");
        press(1, 0, 0);
        do_ticks(3);
        check_all("pause_hold");

        // lap freeze at 05 while count runs to 08
        do_reset("reset2");
        press(1, 0, 0);
        do_ticks(5);
        press(0, 1, 0);
        do_ticks(3);
        check_all("lap05");
        press(0, 1, 0);
        check_all("lap_exit08");

        // bounce: never stable long enough
        do_reset("reset3");
        for (int i = 0; i < 5; i++) begin
            sw_if.start_stop_n = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            sw_if.start_stop_n = 1'b1;
            repeat (2) @(posedge clock);
            #1;
        end
        repeat (10) @(posedge clock);
        #1;
        check_all("bounce");

        // clear with coincident tick, then both buttons from RUN
        press(1, 0, 0);
        do_ticks(12);
        press(1, 0, 0);
        press(0, 1, 1);
        check_all("clear_tick");
        press(1, 0, 0);
        press(1, 1, 0);
        check_all("both_pause");

        // 99 boundary
        do_reset("reset4");
        press(1, 0, 0);
        do_ticks(99);
        check_all("at99");
        do_ticks(1);
        check_all("past99");
        do_ticks(2);
        check_all("past99b");

        // reset mid-RUN at 37, then tick does nothing
        do_reset("reset5");
        press(1, 0, 0);
        do_ticks(37);
        check_all("run37");
        do_reset("reset_mid");
        do_ticks(1);
        check_all("post_reset_tick");

        // random event sequences
        do_reset("reset6");
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 6);
            case (r)
                0:       press(1, 0, 0);
                1:       press(0, 1, 0);
                2, 3:    do_ticks($urandom_range(0, 12));
                4:       press(1, 1, 0);
                5:       press(0, 1, 1);
                default: press(1, 0, 1);
            endcase
            check_all($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the two-digit BCD seconds counter and the seven-segment display path on the DE10-Lite board.
- Debounces the two push-buttons and runs a start/stop/lap/clear state machine. Owns the 00-99 BCD count, which advances on the 1 Hz tick from the clock divider.
- Presents live or lap-frozen digits to the seven-segment decoders.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable clock samples required before a button level is accepted (10 ms at 10 MHz).
- DEBOUNCE_W, 17: width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock (ADC_CLK_10 domain). One clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable pulse from the clock divider (1 Hz).
- start_stop_n  input  1  raw push-button, active-low, asynchronous to clock.
- lap_clr_n  input  1  raw push-button, active-low, asynchronous to clock.
- disp_ones  output  4  BCD ones digit to display (live or lap).
- disp_tens  output  4  BCD tens digit to display (live or lap).
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- overflow  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (async, while high):
  - state=IDLE.
  - Count ones/tens=0; lap registers=0.
  - Synchronizer flops and debounced levels=1 (released); debounce counters=0.
  - All outputs 0.
- Input conditioning, per button:
  - 2-flop synchronizer feeds the debouncer.
  - Debounced level updates when the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
  - A press is a debounced 1->0 transition, producing a registered one-cycle press pulse.
  - Releases produce nothing.
- FSM: the state register samples the press pulses, so the new state is visible on the cycle after the pulse.
  - IDLE: start -> RUN. Lap ignored.
  - RUN: start -> PAUSE. Lap -> LAP, capturing the current count into the lap registers on the same edge.
  - LAP: start -> PAUSE (display returns to live). Lap -> RUN (display returns to live).
  - PAUSE: start -> RUN. Lap -> IDLE and clears the count.
  - Both pulses in the same cycle: start_stop wins; lap is dropped.
- Counting:
  - On tick, if the current (pre-transition) state is RUN or LAP, the count increments.
  - Ones 9 -> 0 with tens+1; 99 -> 00 (default wrap).
  - The count is never written outside RUN/LAP, except for the clear.
  - A tick in the same cycle as the PAUSE->IDLE clear: the clear wins and the count is 00.
- Display:
  - In LAP, disp_* = lap registers. The count keeps running underneath.
  - Otherwise disp_* = live count, registered with 1-cycle latency after a count update.
- Decode: running and lap_active are decoded from the state register.
- Reset mid-operation: immediate return to the reset values above; no pending press survives.

Optional Feature:
- Macro: STOPWATCH_OVERFLOW_STOP_EN.
- Defined:
  - A tick at count 99 in RUN/LAP holds 99, forces state PAUSE and sets overflow=1.
  - overflow clears only on reset or on the PAUSE->IDLE clear.
  - A start press while overflow=1 is ignored.
- Undefined:
  - 99 wraps to 00 and counting continues.
  - overflow is tied to 0.

Test Plan (run with DEBOUNCE_CYCLES=4):
- Reset, press start_stop_n (held low 10 cycles), then 12 ticks -> running=1, display reads 12. Press again -> running=0, display holds 12 through further ticks.
- In RUN at count 05, press lap_clr_n, then 3 ticks -> lap_active=1, display holds 05 while the internal count reaches 08. Press lap again -> display shows 08.
- Bounce start_stop_n low/high every 2 cycles for 20 cycles, then release -> no press accepted, state stays IDLE.
- In PAUSE at 12, assert a lap press in the same cycle as tick -> state IDLE, display 00. Press both buttons in the same cycle from RUN -> PAUSE only.
- Run to 99, then one more tick -> 00 and overflow=0 without the macro; 99, PAUSE and overflow=1 with STOPWATCH_OVERFLOW_STOP_EN.
- Assert reset mid-RUN at count 37 -> all outputs 0, state IDLE; the next tick causes no increment.
